mips_trace_buffer: RTL and testbench

Synthesizable instruction-trace recorder for the MIPS core. Each cycle the core retires an instruction, the buffer records its PC, instruction word and result into a circular memory of parametrised depth. On a PC-match trigger it keeps recording a fixed number of post-trigger entries, then freezes. The frozen window is read out oldest-first through a request/valid handshake. This replaces free-running `$monitor` printing with a bounded, triggerable capture that also works on hardware.

---
 rtl/mips_trace_buffer.sv | 112 +++++++++++
 tb/tb_mips_trace_buffer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_trace_buffer.sv
// Instruction-trace recorder: circular capture of {pc, instr, result} per retired
// instruction, PC-match trigger with a post-trigger window, oldest-first readout.
module mips_trace_buffer #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cap_valid,
  input  logic [DATA_W-1:0]            pc,
  input  logic [DATA_W-1:0]            instr,
  input  logic [DATA_W-1:0]            result,
  input  logic                         arm,
  input  logic                         trig_en,
  input  logic [DATA_W-1:0]            trig_pc,
  input  logic                         rd_req,
  output logic                         rd_valid,
  output logic [DATA_W-1:0]            rd_pc,
  output logic [DATA_W-1:0]            rd_instr,
  output logic [DATA_W-1:0]            rd_result,
  output logic                         armed,
  output logic                         triggered,
  output logic                         done,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // POST_TRIG never exceeds DEPTH-1, so the post counter fits in AW bits.
  localparam logic [AW-1:0] POST_LAST = AW'((POST_TRIG > 0) ? POST_TRIG - 1 : 0);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);

  logic [1:0]          state;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       post_cnt;
  logic [AW-1:0]       rd_idx;
  logic                capturing;
  logic                hit;
  logic                reading;
  logic [3*DATA_W-1:0] mem [DEPTH];

  always_comb begin
    capturing = (state == S_ARMED || state == S_POST) && cap_valid && !arm;
    hit       = capturing && (state == S_ARMED) && trig_en && (pc == trig_pc);
    reading   = (state == S_DONE) && rd_req && (count != '0) && !arm;
    // When full, count[AW-1:0] is 0 and the oldest entry sits at wr_ptr.
    rd_idx    = wr_ptr - count[AW-1:0];
  end

  assign armed     = (state == S_ARMED);
  assign triggered = (state == S_POST) || (state == S_DONE);
  assign done      = (state == S_DONE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      post_cnt <= '0;
      count    <= '0;
    end else if (arm) begin
      state    <= S_ARMED;
      wr_ptr   <= '0;
      post_cnt <= '0;
      count    <= '0;
    end else begin
      if (capturing) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (count != FULL) count <= count + 1'b1;
      end
      if (reading) count <= count - 1'b1;
      case (state)
        S_ARMED: if (hit) begin
          state    <= (POST_TRIG == 0) ? S_DONE : S_POST;
          post_cnt <= '0;
        end
        S_POST: if (capturing) begin
          if (post_cnt == POST_LAST) state <= S_DONE;
          else                       post_cnt <= post_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the trace memory has no reset; only pointers and counters define
  // which entries are meaningful, and leaving it unreset keeps it RAM-mappable.
  always_ff @(posedge clk) begin
    if (capturing) mem[wr_ptr] <= {pc, instr, result};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid  <= 1'b0;
      rd_pc     <= '0;
      rd_instr  <= '0;
      rd_result <= '0;
    end else begin
      rd_valid <= reading;
      if (reading) {rd_pc, rd_instr, rd_result} <= mem[rd_idx];
    end
  end

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed bench for mips_trace_buffer: one instance with POST_TRIG=3 and one
// with POST_TRIG=0, both DEPTH=8, driven from the same stimulus.
module tb_mips_trace_buffer;

  logic        clk;
  logic        reset;
  logic        cap_valid;
  logic [31:0] pc, instr, result;
  logic        arm, trig_en, rd_req;
  logic [31:0] trig_pc;

  logic        rd_valid0, armed0, triggered0, done0;
  logic [31:0] rd_pc0, rd_instr0, rd_result0;
  logic [3:0]  count0;
  logic        rd_valid1, armed1, triggered1, done1;
  logic [31:0] rd_pc1, rd_instr1, rd_result1;
  logic [3:0]  count1;

  int total = 0;
  int bad   = 0;

  mips_trace_buffer #(.DATA_W(32), .DEPTH(8), .POST_TRIG(3)) u_dut0 (
    .clk(clk), .reset(reset), .cap_valid(cap_valid), .pc(pc), .instr(instr),
    .result(result), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .rd_req(rd_req), .rd_valid(rd_valid0), .rd_pc(rd_pc0), .rd_instr(rd_instr0),
    .rd_result(rd_result0), .armed(armed0), .triggered(triggered0),
    .done(done0), .count(count0)
  );

  mips_trace_buffer #(.DATA_W(32), .DEPTH(8), .POST_TRIG(0)) u_dut1 (
    .clk(clk), .reset(reset), .cap_valid(cap_valid), .pc(pc), .instr(instr),
    .result(result), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .rd_req(rd_req), .rd_valid(rd_valid1), .rd_pc(rd_pc1), .rd_instr(rd_instr1),
    .rd_result(rd_result1), .armed(armed1), .triggered(triggered1),
    .done(done1), .count(count1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input logic [31:0] p);
    cap_valid = 1'b1;
    pc        = p;
    instr     = 32'h1000 ^ p;
    result    = 32'h2000 + p;
    cycle();
  endtask

  task automatic do_arm();
    arm       = 1'b1;
    cap_valid = 1'b0;
    rd_req    = 1'b0;
    cycle();
    arm       = 1'b0;
  endtask

  task automatic read_expect(input string tag, input logic [31:0] e, input logic [3:0] cnt_after);
    rd_req = 1'b1;
    cycle();
    rd_req = 1'b0;
    check({tag, "_valid"}, rd_valid0, 1);
    check({tag, "_pc"}, rd_pc0, e);
    check({tag, "_instr"}, rd_instr0, 32'h1000 ^ e);
    check({tag, "_result"}, rd_result0, 32'h2000 + e);
    check({tag, "_count"}, count0, cnt_after);
  endtask

  logic [31:0] gap_exp [7] = '{32'h00, 32'h04, 32'h08, 32'h100, 32'h10, 32'h14, 32'h18};
  logic        gap_cv  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] gap_pc  [5] = '{32'h00, 32'h100, 32'h04, 32'h100, 32'h08};

  initial begin
    reset = 1'b0;
    cap_valid = 0; pc = 0; instr = 0; result = 0;
    arm = 0; trig_en = 0; trig_pc = 0; rd_req = 0;

    // Reset held with random activity on the inputs.
    for (int i = 0; i < 6; i++) begin
      cap_valid = 1'($urandom); arm = 1'($urandom); rd_req = 1'($urandom);
      trig_en = 1'($urandom); pc = $urandom; trig_pc = pc;
      cycle();
    end
    check("rst_count", count0, 0);
    check("rst_armed", armed0, 0);
    check("rst_trig", triggered0, 0);
    check("rst_done", done0, 0);
    check("rst_rdv", rd_valid0, 0);
    check("rst_rdpc", rd_pc0, 0);
    cap_valid = 0; arm = 0; rd_req = 0; trig_en = 0; pc = 0; trig_pc = 0;
    reset = 1'b1;
    cycle();
    check("idle_armed", armed0, 0);

    // Basic capture with trigger at 0x08.
    trig_en = 1'b1; trig_pc = 32'h08;
    do_arm();
    check("arm_armed", armed0, 1);
    check("arm_count", count0, 0);
    for (int i = 0; i < 6; i++) begin
      cap(32'(4 * i));
      if (i == 2) begin
        check("trg_armed", armed0, 0);
        check("trg_trig", triggered0, 1);
        check("trg_done", done0, 0);
      end
      if (i == 4) check("post_done", done0, 0);
    end
    cap_valid = 1'b0;
    check("basic_done", done0, 1);
    check("basic_count", count0, 6);
    for (int k = 0; k < 6; k++) read_expect("basic_rd", 32'(4 * k), 4'(5 - k));
    rd_req = 1'b1;
    cycle();
    rd_req = 1'b0;
    check("empty_rdv", rd_valid0, 0);
    check("empty_count", count0, 0);

    // Wrap-around: 16 captures into 8 entries, keeps 0x20..0x3C.
    trig_pc = 32'h30;
    do_arm();
    for (int i = 0; i < 20; i++) cap(32'(4 * i));
    cap_valid = 1'b0;
    check("wrap_done", done0, 1);
    check("wrap_count", count0, 8);
    for (int k = 0; k < 8; k++) read_expect("wrap_rd", 32'h20 + 32'(4 * k), 4'(7 - k));

    // Gaps: matching PC only while cap_valid is low must not trigger.
    trig_pc = 32'h100;
    do_arm();
    for (int i = 0; i < 5; i++) begin
      cap_valid = gap_cv[i];
      pc        = gap_pc[i];
      instr     = 32'h1000 ^ pc;
      result    = 32'h2000 + pc;
      cycle();
    end
    check("gap_notrig", triggered0, 0);
    check("gap_armed", armed0, 1);
    check("gap_count", count0, 3);
    cap(32'h100);
    check("gap_trig", triggered0, 1);
    cap(32'h10); cap(32'h14); cap(32'h18);
    cap_valid = 1'b0;
    check("gap_done", done0, 1);
    check("gap_count7", count0, 7);
    for (int k = 0; k < 7; k++) read_expect("gap_rd", gap_exp[k], 4'(6 - k));

    // POST_TRIG = 0 instance: trigger entry alone, done right after.
    trig_pc = 32'h40;
    do_arm();
    check("pt0_notdone", done1, 0);
    cap(32'h40);
    cap_valid = 1'b0;
    check("pt0_done", done1, 1);
    check("pt0_trig", triggered1, 1);
    check("pt0_count", count1, 1);
    rd_req = 1'b1;
    cycle();
    rd_req = 1'b0;
    check("pt0_rdv", rd_valid1, 1);
    check("pt0_rdpc", rd_pc1, 32'h40);
    check("pt0_count0", count1, 0);
    cycle();
    check("pt0_rdv_low", rd_valid1, 0);

    // arm beats a same-cycle capture.
    arm = 1'b1; cap_valid = 1'b1; pc = 32'h10;
    cycle();
    arm = 1'b0; cap_valid = 1'b0;
    check("pri_cap_count", count0, 0);
    check("pri_cap_armed", armed0, 1);

    // arm beats a same-cycle read.
    trig_pc = 32'h50;
    cap(32'h50); cap(32'h54); cap(32'h58); cap(32'h5C);
    cap_valid = 1'b0;
    check("pri_done", done0, 1);
    check("pri_count", count0, 4);
    read_expect("pri_rd", 32'h50, 3);
    arm = 1'b1; rd_req = 1'b1;
    cycle();
    arm = 1'b0; rd_req = 1'b0;
    check("pri_rd_rdv", rd_valid0, 0);
    check("pri_rd_armed", armed0, 1);
    check("pri_rd_count", count0, 0);

    // Asynchronous reset in the middle of POST.
    cap(32'h50); cap(32'h54);
    cap_valid = 1'b0;
    check("mid_trig", triggered0, 1);
    check("mid_notdone", done0, 0);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_trig", triggered0, 0);
    check("mid_rst_armed", armed0, 0);
    check("mid_rst_count", count0, 0);
    rd_req = 1'b1;
    cycle();
    rd_req = 1'b0;
    check("mid_rst_rdv", rd_valid0, 0);
    check("mid_rst_done", done0, 0);
    reset = 1'b1;
    cycle();
    check("post_rst_idle", armed0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
